adder: RTL and testbench

ADDER -- requirements
Module: adder

---
 rtl/adder.sv | 51 +++++
 tb/tb_adder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/adder.sv
// n-bit ripple-carry adder: combinational sum/carry-out, plus a registered copy
// of both with one cycle of latency and a synchronous active-high reset.
module adder #(
  parameter int n = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [n-1:0] A,
  input  logic [n-1:0] M,
  output logic [n-1:0] Sum,
  output logic         C,
  output logic [n-1:0] SumReg,
  output logic         CReg
);

  logic [n-1:0] sum_reg;
  logic         c_reg;

  // One full-adder stage per bit.
  // Each stage owns its own carry net, so the chain has no self-dependent vector.
  for (genvar gi = 0; gi < n; gi++) begin : g_stage
    logic c_in;
    logic c_out;

    if (gi == 0) begin : g_first
      assign c_in = 1'b0;
    end else begin : g_rest
      assign c_in = g_stage[gi-1].c_out;
    end

    assign Sum[gi] = A[gi] ^ M[gi] ^ c_in;
    assign c_out   = (A[gi] & M[gi]) | (c_in & (A[gi] ^ M[gi]));
  end

  assign C = g_stage[n-1].c_out;

  // Reset has priority over loading; the combinational outputs ignore it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sum_reg <= '0;
      c_reg   <= 1'b0;
    end else begin
      sum_reg <= Sum;
      c_reg   <= C;
    end
  end

  assign SumReg = sum_reg;
  assign CReg   = c_reg;

endmodule

// File: tb/tb_adder.sv
// Directed bench for adder: combinational sums at n=4 (including an exhaustive
// sweep), the registered path with reset, and spot checks at n=1 and n=8.
module tb_adder;

  logic       clock;
  logic       reset;
  logic [3:0] a4, m4, sum4, sumreg4;
  logic       c4, creg4;
  logic [0:0] a1, m1, sum1, sumreg1;
  logic       c1, creg1;
  logic [7:0] a8, m8, sum8, sumreg8;
  logic       c8, creg8;

  int n_checks = 0;
  int n_fail   = 0;

  adder #(.n(4)) dut (
    .Clock(clock), .Reset(reset), .A(a4), .M(m4),
    .Sum(sum4), .C(c4), .SumReg(sumreg4), .CReg(creg4)
  );

  adder #(.n(1)) dut_n1 (
    .Clock(clock), .Reset(reset), .A(a1), .M(m1),
    .Sum(sum1), .C(c1), .SumReg(sumreg1), .CReg(creg1)
  );

  adder #(.n(8)) dut_n8 (
    .Clock(clock), .Reset(reset), .A(a8), .M(m8),
    .Sum(sum8), .C(c8), .SumReg(sumreg8), .CReg(creg8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    a4 = 4'd0; m4 = 4'd0;
    a1 = 1'b0; m1 = 1'b0;
    a8 = 8'd0; m8 = 8'd0;

    // Reset state
    @(posedge clock); #1;
    check("reset_sumreg", {28'd0, sumreg4}, 32'd0);
    check("reset_creg",   {31'd0, creg4},   32'd0);
    check("reset_sum_comb", {28'd0, sum4},  32'd0);

    // A=0, M=0 with reset released: one edge loads zeros
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    check("zero_sum",    {28'd0, sum4},    32'd0);
    check("zero_c",      {31'd0, c4},      32'd0);
    check("zero_sumreg", {28'd0, sumreg4}, 32'd0);
    check("zero_creg",   {31'd0, creg4},   32'd0);

    // Directed combinational vectors
    a4 = 4'd15; m4 = 4'd1;  #1;
    check("15+1_sum", {28'd0, sum4}, 32'd0);
    check("15+1_c",   {31'd0, c4},   32'd1);
    a4 = 4'd15; m4 = 4'd15; #1;
    check("15+15_sum", {28'd0, sum4}, 32'd14);
    check("15+15_c",   {31'd0, c4},   32'd1);
    a4 = 4'd7;  m4 = 4'd8;  #1;
    check("7+8_sum", {28'd0, sum4}, 32'd15);
    check("7+8_c",   {31'd0, c4},   32'd0);
    a4 = 4'd9;  m4 = 4'd6;  #1;
    check("9+6_sum", {28'd0, sum4}, 32'd15);
    check("9+6_c",   {31'd0, c4},   32'd0);

    // Exhaustive n=4 sweep, operands changed every 2 ns
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a4 = i[3:0]; m4 = j[3:0];
        #1;
        check($sformatf("exh_%0d+%0d", i, j), {27'd0, c4, sum4}, i + j);
        #1;
      end
    end

    // Registered path: 12+5 = 17 -> SumReg=1, CReg=1
    @(negedge clock); a4 = 4'd12; m4 = 4'd5;
    @(posedge clock); #1;
    check("reg_12+5_sumreg", {28'd0, sumreg4}, 32'd1);
    check("reg_12+5_creg",   {31'd0, creg4},   32'd1);

    // Operand change between edges leaves the registers alone
    @(negedge clock); a4 = 4'd2; m4 = 4'd3; #1;
    check("hold_sumreg", {28'd0, sumreg4}, 32'd1);
    check("hold_creg",   {31'd0, creg4},   32'd1);
    check("hold_sum_comb", {28'd0, sum4},  32'd5);
    a4 = 4'd12; m4 = 4'd5;

    // Reset clears registers; combinational result unaffected
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    check("rst_sumreg", {28'd0, sumreg4}, 32'd0);
    check("rst_creg",   {31'd0, creg4},   32'd0);
    check("rst_sum",    {28'd0, sum4},    32'd1);
    check("rst_c",      {31'd0, c4},      32'd1);

    // Reset wins over new operands at the same edge
    @(negedge clock); a4 = 4'd3; m4 = 4'd4;
    @(posedge clock); #1;
    check("prio_sumreg", {28'd0, sumreg4}, 32'd0);
    check("prio_creg",   {31'd0, creg4},   32'd0);

    // First edge after reset falls loads the current sum
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    check("post_rst_sumreg", {28'd0, sumreg4}, 32'd7);
    check("post_rst_creg",   {31'd0, creg4},   32'd0);

    // Parameter sweep: n=1 and n=8
    a1 = 1'b1; m1 = 1'b1;
    a8 = 8'd255; m8 = 8'd255; #1;
    check("n1_max_sum", {31'd0, sum1}, 32'd0);
    check("n1_max_c",   {31'd0, c1},   32'd1);
    check("n8_max_sum", {24'd0, sum8}, 32'd254);
    check("n8_max_c",   {31'd0, c8},   32'd1);
    a1 = 1'b1; m1 = 1'b0;
    a8 = 8'd100; m8 = 8'd27; #1;
    check("n1_1+0_sum", {31'd0, sum1}, 32'd1);
    check("n1_1+0_c",   {31'd0, c1},   32'd0);
    check("n8_100+27",  {23'd0, c8, sum8}, 32'd127);
    a8 = 8'd200; m8 = 8'd100; #1;
    check("n8_200+100", {23'd0, c8, sum8}, 32'd300);
    @(posedge clock); #1;
    check("n8_reg", {23'd0, creg8, sumreg8}, 32'd300);
    check("n1_reg", {30'd0, creg1, sumreg1}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
